// File: rtl/mem_responder.sv
// Memory-side responder: edge-detects read/write strobes, waits WAIT_STATES cycles,
// then serves the request from an internal word RAM with one-cycle rvalid/wack pulses.
module mem_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_wack,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RWAIT   = 3'd1;
    localparam logic [2:0] S_RDATA   = 3'd2;
    localparam logic [2:0] S_WWAIT   = 3'd3;
    localparam logic [2:0] S_WCOMMIT = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_read_q;
    logic              r_write_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_wack;
    logic              r_err;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_rd_rise;
    logic              w_wr_rise;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_accept;
    logic              w_err_nxt;

    assign w_rd_rise = i_read & ~r_read_q;
    assign w_wr_rise = i_write & ~r_write_q;

    // Next-state, wait counter, accept and reject decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_rise && w_wr_rise) begin
                    w_err_nxt = 1'b1;
                end else if (w_rd_rise) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = WS_INIT;
                    w_state_nxt = (WS_INIT == CNT_W'(0)) ? S_RDATA : S_RWAIT;
                end else if (w_wr_rise) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = WS_INIT;
                    w_state_nxt = (WS_INIT == CNT_W'(0)) ? S_WCOMMIT : S_WWAIT;
                end
            end
            S_RWAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) w_state_nxt = S_RDATA;
            end
            S_WWAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) w_state_nxt = S_WCOMMIT;
            end
            S_RDATA:   w_state_nxt = S_IDLE;
            S_WCOMMIT: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (r_state != S_IDLE && (w_rd_rise || w_wr_rise)) w_err_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_read_q  <= 1'b0;
            r_write_q <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_wack    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_read_q  <= i_read;
            r_write_q <= i_write;
            r_rvalid  <= (r_state == S_RDATA);
            r_wack    <= (r_state == S_WCOMMIT);
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_addr_q  <= i_addr;
                r_wdata_q <= i_wdata;
            end
            if (r_state == S_RDATA) r_rdata <= r_mem[r_addr_q];
        end
    end

    // RAM is not reset; a reset before WCOMMIT leaves it untouched
    always_ff @(posedge i_clk) begin
        if (r_state == S_WCOMMIT) r_mem[r_addr_q] <= r_wdata_q;
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_wack   = r_wack;
    assign o_busy   = r_busy;
    assign o_err    = r_err;

endmodule
